// File: rtl/header_insert_core.sv
// -----------------------------------------------------------------------------
// header_insert_core
//
// Merges one header word in front of each AXI-Stream-style payload packet.
// Header bytes and payload bytes are packed contiguously, MSB-first, and the
// byte enables and last flag of the closing beat are recomputed. Outputs are
// combinational; the downstream skid buffer registers them.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   valid_in/data_in/keep_in/last_in, ready_out
//                        payload stream in (byte B-1 is first in stream order)
//   valid_insert/data_insert/keep_insert, ready_insert
//                        header in, right-aligned (low S bytes valid)
//   valid_out/data_out/keep_out/byte_insert_cnt_out/last_out, ready_in
//                        merged stream out (keep contiguous from the MSB)
// -----------------------------------------------------------------------------
module header_insert_core #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
  parameter int BYTE_CNT_WD     = $clog2(DATA_BYTE_WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic [DATA_BYTE_WIDTH-1:0] keep_in,
  input  logic                       last_in,
  output logic                       ready_out,
  input  logic                       valid_insert,
  input  logic [DATA_WIDTH-1:0]      data_insert,
  input  logic [DATA_BYTE_WIDTH-1:0] keep_insert,
  output logic                       ready_insert,
  output logic                       valid_out,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [DATA_BYTE_WIDTH-1:0] keep_out,
  output logic [BYTE_CNT_WD-1:0]     byte_insert_cnt_out,
  output logic                       last_out,
  input  logic                       ready_in
);

  localparam int B  = DATA_BYTE_WIDTH;
  localparam int CW = $clog2(B + 1);              // counts 0..B
  localparam logic [CW:0] B_EXT = (CW + 1)'(B);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] residual;   // bytes carried into the next output beat
  logic [CW-1:0]         s_cnt;      // header bytes S
  logic [CW-1:0]         l_cnt;      // valid bytes L of an overflowing last beat
  logic                  run;        // header intake enabled after reset

  logic [CW-1:0]         l_cur;
  logic                  fits;
  logic [DATA_WIDTH-1:0] raw_data;
  logic [B-1:0]          keep_c;

  function automatic logic [CW-1:0] trailing_ones(input logic [B-1:0] k);
    logic [CW-1:0] n;
    logic          stop;
    n    = '0;
    stop = 1'b0;
    for (int i = 0; i < B; i++) begin
      if (!stop && k[i]) n = n + CW'(1);
      else               stop = 1'b1;
    end
    return n;
  endfunction

  function automatic logic [CW-1:0] leading_ones(input logic [B-1:0] k);
    logic [CW-1:0] n;
    logic          stop;
    n    = '0;
    stop = 1'b0;
    for (int i = B - 1; i >= 0; i--) begin
      if (!stop && k[i]) n = n + CW'(1);
      else               stop = 1'b1;
    end
    return n;
  endfunction

  // Top n byte enables set; n == B gives all ones.
  function automatic logic [B-1:0] top_mask(input logic [CW:0] n);
    return ~({B{1'b1}} >> n);
  endfunction

  assign l_cur = leading_ones(keep_in);
  // The closing payload bytes fit beside the S carried bytes in one beat.
  assign fits  = ({1'b0, l_cur} + {1'b0, s_cnt}) <= B_EXT;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    ready_insert        = run && (state == IDLE);
    valid_out           = 1'b0;
    ready_out           = 1'b0;
    last_out            = 1'b0;
    keep_c              = '0;
    raw_data            = '0;
    byte_insert_cnt_out = '0;
    case (state)
      STREAM: begin
        valid_out           = valid_in;
        ready_out           = ready_in;
        byte_insert_cnt_out = s_cnt[BYTE_CNT_WD-1:0];
        raw_data            = (residual << (8 * (B - int'(s_cnt))))
                            | (data_in >> (8 * int'(s_cnt)));
        if (last_in && fits) begin
          keep_c   = top_mask({1'b0, l_cur} + {1'b0, s_cnt});
          last_out = 1'b1;
        end else begin
          keep_c = '1;
        end
      end
      FLUSH: begin
        valid_out           = 1'b1;
        byte_insert_cnt_out = s_cnt[BYTE_CNT_WD-1:0];
        raw_data            = residual << (8 * (B - int'(s_cnt)));
        keep_c              = top_mask(({1'b0, l_cnt} + {1'b0, s_cnt}) - B_EXT);
        last_out            = 1'b1;
      end
      default: ;
    endcase
  end

  // Bytes outside keep_out are driven to zero so stale residual or payload
  // filler never leaks downstream.
  always_comb begin
    data_out = '0;
    keep_out = keep_c;
    for (int i = 0; i < B; i++) begin
      data_out[8*i +: 8] = keep_c[i] ? raw_data[8*i +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      residual <= '0;
      s_cnt    <= '0;
      l_cnt    <= '0;
      run      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      run <= 1'b1;
      case (state)
        IDLE: begin
          if (valid_insert && ready_insert) begin
            s_cnt    <= trailing_ones(keep_insert);
            // Only the low S bytes matter; the output shift discards the rest.
            residual <= data_insert;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (valid_in && ready_in) begin
            residual <= data_in;
            if (last_in) begin
              if (fits) begin
                state <= IDLE;
              end else begin
                l_cnt <= l_cur;
                state <= FLUSH;
              end
            end
          end
        end
        FLUSH: begin
          if (ready_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_header_insert_core.sv
module tb_header_insert_core;

  localparam int DW      = 32;
  localparam int B       = DW / 8;
  localparam int CW      = $clog2(B);
  localparam int TIMEOUT = 300;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic [B-1:0]  keep_in;
  logic          last_in;
  logic          ready_out;
  logic          valid_insert;
  logic [DW-1:0] data_insert;
  logic [B-1:0]  keep_insert;
  logic          ready_insert;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [B-1:0]  keep_out;
  logic [CW-1:0] byte_insert_cnt_out;
  logic          last_out;
  logic          ready_in;

  always #5 clk = ~clk;

  header_insert_core #(.DATA_WIDTH(DW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .valid_in            (valid_in),
    .data_in             (data_in),
    .keep_in             (keep_in),
    .last_in             (last_in),
    .ready_out           (ready_out),
    .valid_insert        (valid_insert),
    .data_insert         (data_insert),
    .keep_insert         (keep_insert),
    .ready_insert        (ready_insert),
    .valid_out           (valid_out),
    .data_out            (data_out),
    .keep_out            (keep_out),
    .byte_insert_cnt_out (byte_insert_cnt_out),
    .last_out            (last_out),
    .ready_in            (ready_in)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [B-1:0]  keep;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [B-1:0]  keep;
  } hdr_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [B-1:0]  keep;
    logic          last;
    logic [CW-1:0] cnt;
  } exp_t;

  hdr_t  hdr_q[$];
  beat_t pay_q[$];
  exp_t  exp_q[$];

  int n_checks  = 0;
  int n_errors  = 0;
  int mode      = 0;   // ready_in: 0 always 1, 1 random, 3 manual
  int stall_cnt = 0;
  int out_count = 0;
  int hdr_delay = 0;
  bit gaps      = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got no handshake within %0d cycles, expected a handshake", name, TIMEOUT);
  endtask

  function automatic beat_t mk_beat(input logic [DW-1:0] d, input logic [B-1:0] k, input logic l);
    beat_t b;
    b.data = d; b.keep = k; b.last = l;
    return b;
  endfunction

  function automatic exp_t mk_exp(input logic [DW-1:0] d, input logic [B-1:0] k,
                                  input logic l, input logic [CW-1:0] c);
    exp_t e;
    e.data = d; e.keep = k; e.last = l; e.cnt = c;
    return e;
  endfunction

  function automatic logic [B-1:0] top_keep(input int n);
    logic [B-1:0] k;
    k = '0;
    for (int i = 0; i < n; i++) k[B-1-i] = 1'b1;
    return k;
  endfunction

  // Reference model: flatten header + payload into an ordered byte list,
  // then cut it into B-byte beats, zero-padding the final one.
  function automatic void model_packet(input hdr_t h, input beat_t beats[$]);
    byte unsigned bytes[$];
    int           s, n, pos, total;
    exp_t         e;
    s = 0;
    while (s < B && h.keep[s]) s++;
    for (int i = s - 1; i >= 0; i--) bytes.push_back(h.data[8*i +: 8]);
    foreach (beats[k]) begin
      n = 0;
      while (n < B && beats[k].keep[B-1-n]) n++;
      for (int i = 0; i < n; i++) bytes.push_back(beats[k].data[8*(B-1-i) +: 8]);
    end
    total = bytes.size();
    pos   = 0;
    while (pos < total) begin
      e = '0;
      n = (total - pos < B) ? total - pos : B;
      for (int j = 0; j < n; j++) begin
        e.data[8*(B-1-j) +: 8] = bytes[pos+j];
        e.keep[B-1-j]          = 1'b1;
      end
      pos    += n;
      e.last = (pos == total);
      e.cnt  = CW'(s % B);
      exp_q.push_back(e);
    end
  endfunction

  function automatic void add_packet(input hdr_t h, input beat_t beats[$], input bit use_model);
    hdr_q.push_back(h);
    foreach (beats[k]) pay_q.push_back(beats[k]);
    if (use_model) model_packet(h, beats);
  endfunction

  task automatic drive_headers(input int n);
    hdr_t h;
    int   t;
    bit   acc;
    for (int p = 0; p < n && hdr_q.size() > 0; p++) begin
      h = hdr_q.pop_front();
      repeat (hdr_delay) begin @(posedge clk); #1; end
      if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      valid_insert = 1'b1;
      data_insert  = h.data;
      keep_insert  = h.keep;
      acc = 1'b0;
      t   = 0;
      while (!acc) begin
        @(negedge clk);
        acc = ready_insert;
        t++;
        @(posedge clk); #1;
        if (!acc && t > TIMEOUT) begin
          valid_insert = 1'b0;
          timeout_fail("header_handshake");
          return;
        end
      end
      valid_insert = 1'b0;
      data_insert  = $urandom;
    end
  endtask

  task automatic drive_payload(input int n);
    beat_t b;
    int    done_pkts, t;
    bit    acc;
    done_pkts = 0;
    while (done_pkts < n && pay_q.size() > 0) begin
      b = pay_q.pop_front();
      valid_in = 1'b1;
      data_in  = b.data;
      keep_in  = b.keep;
      last_in  = b.last;
      acc = 1'b0;
      t   = 0;
      while (!acc) begin
        @(negedge clk);
        acc = ready_out;
        t++;
        @(posedge clk); #1;
        if (!acc && t > TIMEOUT) begin
          valid_in = 1'b0;
          timeout_fail("payload_handshake");
          return;
        end
      end
      valid_in = 1'b0;
      data_in  = $urandom;
      last_in  = 1'b0;
      if (b.last) done_pkts++;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic run_traffic(input int n);
    fork
      drive_headers(n);
      drive_payload(n);
    join
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d beats still outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // Downstream ready generator.
  initial begin
    ready_in = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mode == 1) begin
        ready_in = ($urandom_range(0, 3) != 0);
      end else if (mode == 0) begin
        if (stall_cnt > 0) begin
          ready_in = 1'b0;
          stall_cnt--;
        end else begin
          ready_in = 1'b1;
        end
      end
    end
  end

  // Monitor: compare every accepted output beat against the scoreboard.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && valid_out && ready_in) begin
      check("ready_insert_busy", ready_insert, 1'b0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", data_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("data_out", data_out, mon_e.data);
        check("keep_out", keep_out, mon_e.keep);
        check("last_out", last_out, mon_e.last);
        check("byte_insert_cnt_out", byte_insert_cnt_out, mon_e.cnt);
      end
      out_count++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  hdr_t  h;
  beat_t bs[$];
  int    s_r, nb_r, l_r;

  initial begin
    rst_n        = 1'b0;
    valid_in     = 1'b0;
    data_in      = '0;
    keep_in      = '0;
    last_in      = 1'b0;
    valid_insert = 1'b0;
    data_insert  = '0;
    keep_insert  = '0;

    // Reset state
    #12;
    check("rst_valid_out", valid_out, 1'b0);
    check("rst_ready_out", ready_out, 1'b0);
    check("rst_ready_insert", ready_insert, 1'b0);
    check("rst_data_out", data_out, '0);
    check("rst_keep_out", keep_out, '0);
    check("rst_last_out", last_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_insert_before_run", ready_insert, 1'b0);
    @(posedge clk); #1;
    check("ready_insert_after_run", ready_insert, 1'b1);

    // Two-beat packet, S=2
    h.data = 32'h0000AABB; h.keep = 4'b0011;
    bs.delete();
    bs.push_back(mk_beat(32'h11223344, 4'b1111, 1'b0));
    bs.push_back(mk_beat(32'h55667788, 4'b1111, 1'b1));
    add_packet(h, bs, 1'b0);
    exp_q.push_back(mk_exp(32'hAABB1122, 4'b1111, 1'b0, 2'd2));
    exp_q.push_back(mk_exp(32'h33445566, 4'b1111, 1'b0, 2'd2));
    exp_q.push_back(mk_exp(32'h77880000, 4'b1100, 1'b1, 2'd2));
    run_traffic(1);
    drain();

    // Full-word header, flush beat
    h.data = 32'hDEADBEEF; h.keep = 4'b1111;
    bs.delete();
    bs.push_back(mk_beat(32'h01020304, 4'b1000, 1'b1));
    add_packet(h, bs, 1'b0);
    exp_q.push_back(mk_exp(32'hDEADBEEF, 4'b1111, 1'b0, 2'd0));
    exp_q.push_back(mk_exp(32'h01000000, 4'b1000, 1'b1, 2'd0));
    run_traffic(1);
    drain();

    // S=1, single beat, payload presented 5 cycles before its header
    h.data = 32'h000000CC; h.keep = 4'b0001;
    bs.delete();
    bs.push_back(mk_beat(32'h11223344, 4'b1110, 1'b1));
    add_packet(h, bs, 1'b0);
    exp_q.push_back(mk_exp(32'hCC112233, 4'b1111, 1'b1, 2'd1));
    hdr_delay = 5;
    fork
      run_traffic(1);
      begin
        repeat (5) begin
          @(negedge clk);
          check("early_payload_ready_out", ready_out, 1'b0);
          check("early_payload_valid_out", valid_out, 1'b0);
        end
      end
    join
    hdr_delay = 0;
    drain();
    @(negedge clk);
    check("idle_after_single_ready_insert", ready_insert, 1'b1);
    check("idle_after_single_valid_out", valid_out, 1'b0);
    @(posedge clk); #1;

    // Backpressure on beat 2 of the two-beat packet
    h.data = 32'h0000AABB; h.keep = 4'b0011;
    bs.delete();
    bs.push_back(mk_beat(32'h11223344, 4'b1111, 1'b0));
    bs.push_back(mk_beat(32'h55667788, 4'b1111, 1'b1));
    add_packet(h, bs, 1'b0);
    exp_q.push_back(mk_exp(32'hAABB1122, 4'b1111, 1'b0, 2'd2));
    exp_q.push_back(mk_exp(32'h33445566, 4'b1111, 1'b0, 2'd2));
    exp_q.push_back(mk_exp(32'h77880000, 4'b1100, 1'b1, 2'd2));
    out_count = 0;
    fork
      run_traffic(1);
      begin
        for (int t = 0; t < TIMEOUT && out_count < 1; t++) @(posedge clk);
        if (out_count < 1) begin
          timeout_fail("bp_first_beat");
        end else begin
          stall_cnt = 3;
          repeat (3) begin
            @(negedge clk);
            check("bp_valid_out", valid_out, 1'b1);
            check("bp_data_out", data_out, 32'h33445566);
            check("bp_keep_out", keep_out, 4'b1111);
            check("bp_ready_out", ready_out, 1'b0);
            check("bp_ready_insert", ready_insert, 1'b0);
          end
        end
      end
    join
    drain();

    // Asynchronous reset in the middle of a packet
    mode     = 3;
    ready_in = 1'b0;
    valid_insert = 1'b1;
    data_insert  = 32'h0000AABB;
    keep_insert  = 4'b0011;
    @(negedge clk);
    check("mid_rst_hdr_ready", ready_insert, 1'b1);
    @(posedge clk); #1;
    valid_insert = 1'b0;
    valid_in     = 1'b1;
    data_in      = 32'h11223344;
    keep_in      = 4'b1111;
    last_in      = 1'b0;
    @(negedge clk); #1;
    ready_in = 1'b1;
    #1;
    check("pre_rst_valid_out", valid_out, 1'b1);
    check("pre_rst_ready_out", ready_out, 1'b1);
    check("pre_rst_data_out", data_out, 32'hAABB1122);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid_out", valid_out, 1'b0);
    check("mid_rst_ready_out", ready_out, 1'b0);
    check("mid_rst_ready_insert", ready_insert, 1'b0);
    ready_in = 1'b0;
    valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready_insert_low", ready_insert, 1'b0);
    @(posedge clk); #1;
    check("post_rst_ready_insert_high", ready_insert, 1'b1);
    ready_in = 1'b1;
    mode     = 0;

    // Clean packet after reset
    h.data = 32'h0000AABB; h.keep = 4'b0011;
    bs.delete();
    bs.push_back(mk_beat(32'h11223344, 4'b1111, 1'b0));
    bs.push_back(mk_beat(32'h55667788, 4'b1111, 1'b1));
    add_packet(h, bs, 1'b1);
    run_traffic(1);
    drain();

    // Randomized traffic with pipelined headers, gaps and backpressure
    mode = 1;
    gaps = 1'b1;
    for (int p = 0; p < 40; p++) begin
      s_r    = $urandom_range(1, B);
      h.data = $urandom;
      h.keep = '0;
      for (int i = 0; i < s_r; i++) h.keep[i] = 1'b1;
      nb_r = $urandom_range(1, 4);
      bs.delete();
      for (int k = 0; k < nb_r; k++) begin
        l_r = (k == nb_r - 1) ? $urandom_range(1, B) : B;
        bs.push_back(mk_beat($urandom, top_keep(l_r), k == nb_r - 1));
      end
      add_packet(h, bs, 1'b1);
    end
    run_traffic(40);
    drain();
    mode = 0;
    gaps = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/header_insert_core.md
Name: header_insert_core

Overview:
- Merges one header word per packet in front of an AXI-Stream-style data packet.
- Packs header bytes and payload bytes contiguously, MSB-first, and recomputes keep/last for the final beat.
- Sits directly upstream of the pipeline skid buffer and drives its valid/data/keep/byte_insert_cnt/last inputs; that stage registers all outputs and breaks timing paths.

Parameters:
- DATA_WIDTH, 32, stream data width in bits (multiple of 8).
- DATA_BYTE_WIDTH, DATA_WIDTH/8, bytes per beat (B).
- BYTE_CNT_WD, $clog2(DATA_BYTE_WIDTH), width of the header byte count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  upstream payload beat valid.
- data_in  in  DATA_WIDTH  payload beat; byte B-1 (MSB) is the first byte in stream order.
- keep_in  in  DATA_BYTE_WIDTH  payload byte enables.
- last_in  in  1  last payload beat of the packet.
- ready_out  out  1  payload ready to upstream.
- valid_insert  in  1  header valid.
- data_insert  in  DATA_WIDTH  header, right-aligned: the low S bytes are valid.
- keep_insert  in  DATA_BYTE_WIDTH  header enables, contiguous from the LSB, never 0.
- ready_insert  out  1  header ready.
- valid_out  out  1  merged beat valid to the skid buffer.
- data_out  out  DATA_WIDTH  merged beat.
- keep_out  out  DATA_BYTE_WIDTH  merged byte enables, contiguous from the MSB.
- byte_insert_cnt_out  out  BYTE_CNT_WD  S mod B for the current packet.
- last_out  out  1  last merged beat.
- ready_in  in  1  downstream ready, from the skid buffer.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n; all flops clear immediately on assertion.
- Reset values:
  - FSM goes to IDLE; the residual, S, L and run registers clear to 0.
  - All outputs are 0, including ready_insert.
  - run is set on the first clk edge after rst_n deasserts. ready_insert = run && state==IDLE.
- Derived counts:
  - S = number of trailing ones in keep_insert (1..B), latched on the header handshake.
  - L = number of leading ones in keep_in (1..B). keep_in must be all ones on non-last beats.
- IDLE state:
  - ready_out=0, valid_out=0.
  - On valid_insert && ready_insert: latch S, load residual <= data_insert (low S bytes meaningful), go to STREAM.
  - Payload arriving before its header waits; there is no loss and no valid_out.
- STREAM state (combinational outputs):
  - valid_out = valid_in; ready_out = ready_in; ready_insert=0.
  - data_out = (residual << 8*(B-S)) | (data_in >> 8*S).
  - byte_insert_cnt_out = S[BYTE_CNT_WD-1:0].
  - On non-last beats: keep_out = all ones, last_out = 0.
- STREAM on a last beat:
  - If L <= B-S: keep_out = top (S+L) bits set, last_out=1, next state IDLE.
  - Otherwise: keep_out = all ones, last_out=0, latch L, next state FLUSH.
- STREAM handshake (valid_in && ready_in): residual <= low S bytes of data_in.
- FLUSH state:
  - valid_out=1; data_out = residual << 8*(B-S).
  - keep_out = top (L-(B-S)) bits set, last_out=1; ready_out=0.
  - On ready_in, go to IDLE.
- Backpressure: with ready_in=0, data_out, keep_out and last_out are held stable, since upstream must hold its beat (AXI rule) and the residual is unchanged.
- Header ordering: a header presented mid-packet is held off (ready_insert=0) until the FSM returns to IDLE.
- Throughput: one bubble cycle in IDLE between packets is accepted; no same-cycle header accept on the packet's last beat.
- Output path: outputs are combinational from state/registers/inputs; the downstream skid buffer provides the registering.
- Reset mid-packet: the partial packet is discarded, outputs go to 0 immediately, and the next header starts cleanly.

Test Plan:
- Two-beat packet, S=2: header 0x0000AABB keep 0011; beats 0x11223344 keep 1111, then 0x55667788 keep 1111 last -> out 0xAABB1122/1111, 0x33445566/1111, 0x77880000/1100 last. byte_insert_cnt_out=2.
- Full-word header with flush, S=4: header 0xDEADBEEF keep 1111; beat 0x01020304 keep 1000 last -> 0xDEADBEEF/1111 last=0, then 0x01000000/1000 last. byte_insert_cnt_out=0.
- No flush, S=1: header 0x000000CC keep 0001; beat 0x11223344 keep 1110 last (L=3) -> single beat 0xCC112233/1111 last, back in IDLE next cycle.
- Backpressure: repeat the two-beat packet with ready_in=0 for 3 cycles on beat 2 -> valid_out stays 1, data_out holds 0x33445566, ready_out=0, output sequence identical.
- Ordering holds:
  - valid_in=1 for 5 cycles with no header -> ready_out=0, valid_out=0.
  - A second header during a packet -> ready_insert=0 until after last_out is accepted.
- Async reset: drop rst_n mid-STREAM -> valid_out, ready_out and ready_insert are 0 immediately. After release, ready_insert=1 one cycle later and a new packet merges correctly.
